tm_core_v2: RTL and testbench

Parametrised successor of the chip's Turing-machine core, with a loadable rule table instead of a fixed program. Phases: tape is loaded symbol-by-symbol, the machine runs one transition per clock, and the tape is read out afterwards. Adds over the previous generation:
- configurable symbol width, tape length and state count;
- step-limit timeout;
- tape-boundary fault detection;
- error codes;
- wrap-around tape dump.

Sits directly under the chip top; the top maps io_in/io_out onto these ports.

---
 rtl/tm_pkg.sv | 42 ++++
 rtl/tm_edge_detect.sv | 26 ++
 rtl/tm_core_v2.sv | 188 ++++++++++++++++++
 tb/tb_tm_core_v2.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_pkg.sv
// rtl/tm_pkg.sv - shared types, constants and rule-field helpers for the Turing-machine core
// Contents:
//   ctrl_t       : machine phase (LOAD, RUN, DUMP, ERROR)
//   MV_*         : head move codes carried in a rule entry (2'b11 behaves as stay)
//   err_t        : error code presented on the err output
//   rule_move / rule_wsym / rule_next : slice a rule word {move, write_sym, next_state}
package tm_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DUMP  = 2'd2,
        ERROR = 2'd3
    } ctrl_t;

    localparam logic [1:0] MV_STAY  = 2'b00;
    localparam logic [1:0] MV_LEFT  = 2'b01;
    localparam logic [1:0] MV_RIGHT = 2'b10;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_BOUND   = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    // Rule words are zero-extended to 32 bits before slicing so one helper
    // serves every parameterisation; callers cast the result to field width.
    function automatic logic [1:0] rule_move(input logic [31:0] rule, input int sym_w,
                                             input int state_w);
        return 2'(rule >> (sym_w + state_w));
    endfunction

    function automatic logic [31:0] rule_wsym(input logic [31:0] rule, input int sym_w,
                                              input int state_w);
        return (rule >> state_w) & ((32'd1 << sym_w) - 32'd1);
    endfunction

    function automatic logic [31:0] rule_next(input logic [31:0] rule, input int state_w);
        return rule & ((32'd1 << state_w) - 32'd1);
    endfunction

endpackage

// File: rtl/tm_edge_detect.sv
// rtl/tm_edge_detect.sv - rising-edge pulse generator for a synchronous level input
// Ports:
//   clock   : clock
//   reset_n : asynchronous active-low reset (previous level cleared to 0)
//   level   : synchronous level input
//   pulse   : high for the cycle where level is 1 and was 0 the cycle before
module tm_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/tm_core_v2.sv
// rtl/tm_core_v2.sv - Turing-machine core with loadable rule table, bound/timeout faults and tape dump
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   sym_in, next, done      : load symbol, load/advance strobe level, start/return strobe level
//   rule_we/addr/data       : rule-table write port, {state, read_sym} -> {move, write_sym, next_state}
//   out_sym, out_pos        : displayed tape cell and its index
//   head_pos, step_count    : head position and transitions executed
//   busy, halted, err       : running, halted normally, error code
module tm_core_v2
    import tm_pkg::*;
#(
    parameter int SYM_W     = 4,
    parameter int TAPE_LEN  = 64,
    parameter int STATE_W   = 3,
    parameter int MAX_STEPS = 4096
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [SYM_W-1:0]                  sym_in,
    input  logic                              next,
    input  logic                              done,
    input  logic                              rule_we,
    input  logic [STATE_W+SYM_W-1:0]          rule_addr,
    input  logic [STATE_W+SYM_W+1:0]          rule_data,
    output logic [SYM_W-1:0]                  out_sym,
    output logic [$clog2(TAPE_LEN)-1:0]       out_pos,
    output logic [$clog2(TAPE_LEN)-1:0]       head_pos,
    output logic [$clog2(MAX_STEPS+1)-1:0]    step_count,
    output logic                              busy,
    output logic                              halted,
    output logic [1:0]                        err
);

    localparam int AW    = $clog2(TAPE_LEN);
    localparam int SCW   = $clog2(MAX_STEPS + 1);
    localparam int RA_W  = STATE_W + SYM_W;
    localparam int RD_W  = STATE_W + SYM_W + 2;
    localparam int RULES = 1 << RA_W;

    localparam logic [STATE_W-1:0] HALT       = '1;
    localparam logic [AW-1:0]      LAST_CELL  = AW'(TAPE_LEN - 1);
    localparam logic [SCW-1:0]     STEP_LIMIT = SCW'(MAX_STEPS);

    logic [SYM_W-1:0]   tape  [TAPE_LEN];
    logic [RD_W-1:0]    rules [RULES];

    ctrl_t              ctrl_q, ctrl_d;
    err_t               err_q, err_d;
    logic [AW-1:0]      load_ptr, dump_ptr, head_q, head_target;
    logic [STATE_W-1:0] state_q;
    logic [SCW-1:0]     step_q;
    logic               next_edge, done_edge;

    logic [RD_W-1:0]    cur_rule;
    logic [1:0]         cur_move;
    logic [SYM_W-1:0]   cur_wsym;
    logic [STATE_W-1:0] cur_next;
    logic               hit_bound, hit_halt, hit_timeout;

    tm_edge_detect u_next_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .level   (next),
        .pulse   (next_edge)
    );

    tm_edge_detect u_done_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .level   (done),
        .pulse   (done_edge)
    );

    // Decode the transition that fires this cycle if the machine is in RUN.
    assign cur_rule = rules[{state_q, tape[head_q]}];

    always_comb begin
        cur_move    = rule_move(32'(cur_rule), SYM_W, STATE_W);
        cur_wsym    = SYM_W'(rule_wsym(32'(cur_rule), SYM_W, STATE_W));
        cur_next    = STATE_W'(rule_next(32'(cur_rule), STATE_W));
        head_target = head_q;
        hit_bound   = 1'b0;
        if (cur_move == MV_LEFT) begin
            if (head_q == '0) hit_bound = 1'b1;
            else              head_target = head_q - AW'(1);
        end else if (cur_move == MV_RIGHT) begin
            if (head_q == LAST_CELL) hit_bound = 1'b1;
            else                     head_target = head_q + AW'(1);
        end
        hit_halt    = (cur_next == HALT);
        hit_timeout = ((step_q + SCW'(1)) == STEP_LIMIT);
    end

    // Phase control; a done edge always beats a simultaneous next edge.
    always_comb begin
        ctrl_d = ctrl_q;
        err_d  = err_q;
        unique case (ctrl_q)
            LOAD: if (done_edge) ctrl_d = RUN;
            RUN: begin
                if (hit_bound) begin
                    ctrl_d = ERROR;
                    err_d  = ERR_BOUND;
                end else if (hit_halt) begin
                    ctrl_d = DUMP;
                end else if (hit_timeout) begin
                    ctrl_d = ERROR;
                    err_d  = ERR_TIMEOUT;
                end
            end
            DUMP, ERROR: begin
                if (done_edge) begin
                    ctrl_d = LOAD;
                    err_d  = ERR_NONE;
                end
            end
            default: ctrl_d = LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= LOAD;
            err_q  <= ERR_NONE;
        end else begin
            ctrl_q <= ctrl_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPE_LEN; i++) tape[i] <= '0;
            for (int i = 0; i < RULES; i++)    rules[i] <= '0;
            load_ptr <= '0;
            dump_ptr <= '0;
            head_q   <= '0;
            state_q  <= '0;
            step_q   <= '0;
        end else begin
            unique case (ctrl_q)
                LOAD: begin
                    if (rule_we) rules[rule_addr] <= rule_data;
                    if (done_edge) begin
                        head_q  <= '0;
                        state_q <= '0;
                        step_q  <= '0;
                    end else if (next_edge) begin
                        tape[load_ptr] <= sym_in;
                        if (load_ptr != LAST_CELL) load_ptr <= load_ptr + AW'(1);
                    end
                end
                RUN: begin
                    // The write lands even when the move faults; head_target holds then.
                    tape[head_q] <= cur_wsym;
                    state_q      <= cur_next;
                    step_q       <= step_q + SCW'(1);
                    head_q       <= head_target;
                    if (ctrl_d != RUN) dump_ptr <= '0;
                end
                DUMP, ERROR: begin
                    if (done_edge) begin
                        load_ptr <= '0;
                    end else if (next_edge) begin
                        dump_ptr <= (dump_ptr == LAST_CELL) ? '0 : dump_ptr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        unique case (ctrl_q)
            LOAD:    out_pos = load_ptr;
            RUN:     out_pos = head_q;
            default: out_pos = dump_ptr;
        endcase
    end

    assign out_sym    = tape[out_pos];
    assign head_pos   = head_q;
    assign step_count = step_q;
    assign busy       = (ctrl_q == RUN);
    assign halted     = (ctrl_q == DUMP);
    assign err        = err_q;

endmodule

// File: tb/tb_tm_core_v2.sv
// tb/tb_tm_core_v2.sv - self-checking bench for tm_core_v2 against a behavioural tape-machine model
module tb_tm_core_v2;

    localparam int SYM_W     = 4;
    localparam int TAPE_LEN  = 64;
    localparam int STATE_W   = 3;
    localparam int MAX_STEPS = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] sym_in;
    logic       next, done, rule_we;
    logic [6:0] rule_addr;
    logic [8:0] rule_data;
    logic [3:0] out_sym;
    logic [5:0] out_pos, head_pos;
    logic [4:0] step_count;
    logic       busy, halted;
    logic [1:0] err;

    tm_core_v2 #(
        .SYM_W     (SYM_W),
        .TAPE_LEN  (TAPE_LEN),
        .STATE_W   (STATE_W),
        .MAX_STEPS (MAX_STEPS)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sym_in     (sym_in),
        .next       (next),
        .done       (done),
        .rule_we    (rule_we),
        .rule_addr  (rule_addr),
        .rule_data  (rule_data),
        .out_sym    (out_sym),
        .out_pos    (out_pos),
        .head_pos   (head_pos),
        .step_count (step_count),
        .busy       (busy),
        .halted     (halted),
        .err        (err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 load, 1 run, 2 dump, 3 error.
    int m_tape [TAPE_LEN];
    int m_rules [128];
    int m_phase, m_lp, m_dp, m_head, m_state, m_steps, m_err;
    bit m_pn, m_pd;

    always @(posedge clock or negedge reset_n) begin : model
        int r, mv, ws, ns, tgt;
        bit ne, de;
        if (!reset_n) begin
            foreach (m_tape[i]) m_tape[i] = 0;
            foreach (m_rules[i]) m_rules[i] = 0;
            m_phase = 0; m_lp = 0; m_dp = 0; m_head = 0;
            m_state = 0; m_steps = 0; m_err = 0; m_pn = 0; m_pd = 0;
        end else begin
            ne = next && !m_pn;
            de = done && !m_pd;
            m_pn = next;
            m_pd = done;
            case (m_phase)
                0: begin
                    if (rule_we) m_rules[rule_addr] = rule_data;
                    if (de) begin
                        m_phase = 1; m_head = 0; m_state = 0; m_steps = 0;
                    end else if (ne) begin
                        m_tape[m_lp] = sym_in;
                        if (m_lp < TAPE_LEN - 1) m_lp++;
                    end
                end
                1: begin
                    r  = m_rules[m_state * 16 + m_tape[m_head]];
                    ns = r % 8;
                    ws = (r / 8) % 16;
                    mv = r / 128;
                    m_tape[m_head] = ws;
                    m_state = ns;
                    m_steps++;
                    tgt = m_head + ((mv == 1) ? -1 : (mv == 2) ? 1 : 0);
                    if (tgt < 0 || tgt >= TAPE_LEN) begin
                        m_err = 1; m_phase = 3; m_dp = 0;
                    end else begin
                        m_head = tgt;
                        if (ns == 7) begin
                            m_phase = 2; m_dp = 0;
                        end else if (m_steps == MAX_STEPS) begin
                            m_err = 2; m_phase = 3; m_dp = 0;
                        end
                    end
                end
                default: begin
                    if (de) begin
                        m_phase = 0; m_lp = 0; m_err = 0;
                    end else if (ne) begin
                        m_dp = (m_dp + 1) % TAPE_LEN;
                    end
                end
            endcase
        end
    end

    always @(negedge clock) begin
        int ep;
        if (chk_en) begin
            ep = (m_phase == 0) ? m_lp : (m_phase == 1) ? m_head : m_dp;
            check("out_pos", out_pos, ep);
            check("out_sym", out_sym, m_tape[ep]);
            check("head_pos", head_pos, m_head);
            check("step_count", step_count, m_steps);
            check("busy", busy, m_phase == 1);
            check("halted", halted, m_phase == 2);
            check("err", err, m_err);
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; next = 1'b0; done = 1'b0; rule_we = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic pulse_next(input int s);
        sym_in = 4'(s); next = 1'b1; step();
        next = 1'b0; step();
    endtask

    function automatic logic [8:0] mk_rule(input int mv, input int ws, input int ns);
        return 9'(mv * 128 + ws * 8 + ns);
    endfunction

    task automatic write_rule(input int st, input int sym, input logic [8:0] data);
        rule_we = 1'b1; rule_addr = 7'(st * 16 + sym); rule_data = data; step();
        rule_we = 1'b0;
    endtask

    // Starts a run and counts the cycles for which busy is seen high.
    task automatic run_count(output int n);
        int guard;
        done = 1'b1; step();
        done = 1'b0;
        n = 0; guard = 0;
        while (busy && guard < 200) begin
            n++; guard++; step();
        end
        if (guard >= 200) check("run_bound", 0, 1);
    endtask

    int n;
    int seq [TAPE_LEN];

    initial begin
        sym_in = '0; next = 1'b0; done = 1'b0; rule_we = 1'b0;
        rule_addr = '0; rule_data = '0;
        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        chk_en = 1'b1;
        step();
        check("rst_out_pos", out_pos, 0);
        check("rst_out_sym", out_sym, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_steps", step_count, 0);
        pulse_next(5);
        check("load_ptr_inc", out_pos, 1);
        check("model_tape0", m_tape[0], 5);

        // Unary increment.
        do_reset();
        write_rule(0, 1, mk_rule(2, 1, 0));
        write_rule(0, 0, mk_rule(0, 1, 7));
        pulse_next(1); pulse_next(1); pulse_next(1); pulse_next(0);
        run_count(n);
        check("inc_busy_cycles", n, 4);
        check("inc_halted", halted, 1);
        check("inc_steps", step_count, 4);
        check("inc_head", head_pos, 3);
        check("inc_err", err, 0);
        for (int i = 0; i < TAPE_LEN; i++) begin
            seq[i] = int'(out_sym);
            pulse_next(0);
        end
        check("dump_wrap_pos", out_pos, 0);
        check("dump_sym0", seq[0], 1);
        check("dump_sym1", seq[1], 1);
        check("dump_sym2", seq[2], 1);
        check("dump_sym3", seq[3], 1);
        check("dump_sym4", seq[4], 0);
        done = 1'b1; step(); done = 1'b0; step();
        check("back_load_pos", out_pos, 0);
        check("back_load_head", head_pos, 3);

        // Left move off cell 0.
        do_reset();
        write_rule(0, 0, mk_rule(1, 7, 0));
        run_count(n);
        check("bound_cycles", n, 1);
        check("bound_err", err, 1);
        check("bound_head", head_pos, 0);
        check("bound_sym", out_sym, 7);
        check("bound_busy", busy, 0);

        // All-zero rules run into the step limit.
        do_reset();
        run_count(n);
        check("timeout_cycles", n, MAX_STEPS);
        check("timeout_err", err, 2);
        check("timeout_steps", step_count, MAX_STEPS);

        // next and done together: no tape write, run starts.
        do_reset();
        write_rule(0, 0, mk_rule(2, 3, 7));
        write_rule(0, 9, mk_rule(2, 5, 7));
        sym_in = 4'd9; next = 1'b1; done = 1'b1; step();
        check("simul_busy", busy, 1);
        next = 1'b0; done = 1'b0; step();
        check("simul_halted", halted, 1);
        check("simul_tape0", out_sym, 3);
        check("simul_head", head_pos, 1);

        // Reset in the middle of a run.
        do_reset();
        done = 1'b1; step(); done = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("midrun_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_pos", out_pos, 0);
        check("midrun_rst_head", head_pos, 0);
        check("midrun_rst_steps", step_count, 0);
        check("midrun_rst_sym", out_sym, 0);
        step();
        reset_n = 1'b1;
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            sym_in    = 4'($urandom);
            rule_we   = ($urandom_range(0, 2) == 0);
            rule_addr = 7'($urandom);
            rule_data = mk_rule($urandom_range(0, 3), $urandom_range(0, 15),
                                ($urandom_range(0, 3) == 0) ? 7 : $urandom_range(0, 7));
            next      = 1'($urandom);
            done      = ($urandom_range(0, 11) == 0);
            step();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
